data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in storage; power of two, range 4..4096.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning extra wait states inserted between request acceptance and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 reqValid  input  1  core presents a load/store request.
REQ-006 reqWrite  input  1  1 = store, 0 = load.
REQ-007 reqFunc3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 reqAddr  input  32  byte address.
REQ-009 reqWdata  input  32  store data; low-order bytes used for b/h.
REQ-010 reqReady  output  1  block can accept a request this cycle.
REQ-011 respValid  output  1  response valid, one-cycle pulse.
REQ-012 respData  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-013 respErr  output  1  request was misaligned or had an illegal funct3; qualified by respValid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge where reqValid=1 and reqReady=1.
REQ-016 On acceptance, the block SHALL latch reqWrite, reqFunc3, reqAddr and reqWdata; later input changes SHALL NOT affect the transaction.
REQ-017 Acceptance SHALL move IDLE->WAIT with a counter loaded to WAIT_CYCLES-1, or IDLE->RESP directly when WAIT_CYCLES=0.
REQ-018 WAIT SHALL decrement the counter each edge and move to RESP on the edge where the counter equals 0.
REQ-019 In RESP, respValid SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE on the next edge.
REQ-020 Latency SHALL be fixed: respValid is high in cycle A+WAIT_CYCLES+1, where A is the acceptance edge; throughput is one request per WAIT_CYCLES+2 cycles.
REQ-021 The storage word index SHALL be reqAddr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 Stores SHALL commit on the edge entering RESP with these byte lanes:
  - sb: lane addr[1:0], data = wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0], little-endian.
  - sw: all four lanes.
REQ-023 Loads SHALL read the addressed word on the edge entering RESP and extract the addressed byte or half:
  - lb and lh are sign-extended.
  - lbu and lhu are zero-extended.
  - lw returns the whole word.
REQ-024 An error condition SHALL be any of: a half access with addr[0]=1; a word access with addr[1:0]!=00; funct3 of 011, 110 or 111; a store with funct3 100 or 101.
REQ-025 On an error, no storage SHALL be modified, respData SHALL be 0 and respErr SHALL be 1 during RESP.
REQ-026 respData and respErr SHALL be held at 0 whenever respValid=0.
REQ-027 reqValid asserted in WAIT or RESP SHALL be ignored and never queued; the core must hold it until reqReady=1.
REQ-028 A load that follows a store to the same word SHALL return the newly stored data.

Reset
REQ-029 While reset=1, regardless of clk:
  - the state SHALL be IDLE and the counter 0;
  - reqReady SHALL be 1;
  - respValid, respErr and respData SHALL be 0.
REQ-030 Asserting reset during WAIT SHALL abort the transaction with no store committed and no response issued.
REQ-031 Storage contents SHALL NOT be cleared by reset; they are loadable by the bench via hierarchical memory initialization.

Verification
REQ-032 Word round trip, WAIT_CYCLES=2: sw addr 0x10 data 0xDEADBEEF, then lw addr 0x10 -> each respValid pulse occurs 3 cycles after acceptance; the load returns 0xDEADBEEF with respErr=0.
REQ-033 Byte and half extraction: the word at 0x20 holds 0x80FF7F01. Required results:
  - lb 0x22 -> 0xFFFFFFFF.
  - lbu 0x23 -> 0x00000080.
  - lh 0x20 -> 0x00007F01.
  - lhu 0x22 -> 0x000080FF.
REQ-034 Partial store: the word at 0x30 holds 0x11223344. sb 0x31 data 0xAA gives 0x1122AA44; then sh 0x32 data 0xBEEF gives 0xBEEFAA44, checked by lw.
REQ-035 Errors: lw 0x41, sh 0x43 and funct3 011 -> respErr=1, respData=0, storage unchanged.
REQ-036 Reset and ready: reset asserted mid-WAIT of sw 0x50 data 0x12345678 -> outputs reach reset values immediately and a later lw 0x50 returns the old value. During WAIT, reqReady=0 and a new reqValid is not accepted until IDLE.
REQ-037 Boundaries: with WAIT_CYCLES=0, respValid occurs 1 cycle after acceptance. With DEPTH_WORDS=256, an access at 0x400 aliases to 0x000.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory that answers RISC-V style load/store requests
//   after a fixed number of wait states. One transaction is in flight at a
//   time; the core must hold reqValid until reqReady is seen high.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage (power of two, 4..4096)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (storage is not cleared)
//   reqValid   request present
//   reqWrite   1 = store, 0 = load
//   reqFunc3   funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   reqAddr    byte address (wraps modulo DEPTH_WORDS*4)
//   reqWdata   store data, low-order bytes used for b/h
//   reqReady   high only while idle; request accepted when reqValid & reqReady
//   respValid  one-cycle response pulse
//   respData   extended load data; 0 for stores, errors and when not valid
//   respErr    misaligned access or illegal funct3; 0 when not valid
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunc3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        reqReady,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int ADDR_W = IDX_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              latWrite;
  logic [2:0]        latFunc3;
  logic [ADDR_W-1:0] latAddr;
  logic [31:0]       latWdata;
  logic [31:0]       dataReg;
  logic              errReg;

  logic [31:0] mem [DEPTH_WORDS];

  // Address bits above the storage range are deliberately ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^reqAddr[31:ADDR_W];

  logic accept;
  logic enterResp;
  assign accept    = reqValid && (state == IDLE);
  // With zero wait states the acceptance edge is also the edge entering RESP.
  assign enterResp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));

  // The transaction being executed comes straight from the inputs on the
  // acceptance edge and from the latched copy on every later edge.
  logic              curWrite;
  logic [2:0]        curFunc3;
  logic [ADDR_W-1:0] curAddr;
  logic [31:0]       curWdata;
  assign curWrite = (state == IDLE) ? reqWrite            : latWrite;
  assign curFunc3 = (state == IDLE) ? reqFunc3            : latFunc3;
  assign curAddr  = (state == IDLE) ? reqAddr[ADDR_W-1:0] : latAddr;
  assign curWdata = (state == IDLE) ? reqWdata            : latWdata;

  logic [IDX_W-1:0] curIdx;
  logic [1:0]       lane;
  logic [31:0]      rdWord;
  assign curIdx = curAddr[ADDR_W-1:2];
  assign lane   = curAddr[1:0];
  assign rdWord = mem[curIdx];

  logic        err;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadVal;
  logic [3:0]  wrMask;
  logic [31:0] wrData;

  // NOTE: every signal written in always_comb gets a default first so that no
  // path through the case statements leaves it unassigned (which would infer a latch).
  always_comb begin
    err     = 1'b0;
    loadVal = 32'd0;
    wrMask  = 4'b0000;
    wrData  = 32'd0;
    byteVal = rdWord[{lane, 3'b000} +: 8];
    halfVal = curAddr[1] ? rdWord[31:16] : rdWord[15:0];
    case (curFunc3)
      3'b000: begin
        loadVal = {{24{byteVal[7]}}, byteVal};
        wrMask  = 4'b0001 << lane;
        wrData  = {4{curWdata[7:0]}};
      end
      3'b001: begin
        err     = curAddr[0];
        loadVal = {{16{halfVal[15]}}, halfVal};
        wrMask  = curAddr[1] ? 4'b1100 : 4'b0011;
        wrData  = {2{curWdata[15:0]}};
      end
      3'b010: begin
        err     = |curAddr[1:0];
        loadVal = rdWord;
        wrMask  = 4'b1111;
        wrData  = curWdata;
      end
      3'b100: begin
        err     = curWrite;
        loadVal = {24'd0, byteVal};
      end
      3'b101: begin
        err     = curWrite || curAddr[0];
        loadVal = {16'd0, halfVal};
      end
      default: err = 1'b1;
    endcase
  end

  logic commit;
  assign commit = enterResp && curWrite && !err && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      latWrite <= 1'b0;
      latFunc3 <= 3'd0;
      latAddr  <= '0;
      latWdata <= 32'd0;
      dataReg  <= 32'd0;
      errReg   <= 1'b0;
    end else begin
      if (enterResp) begin
        errReg  <= err;
        dataReg <= (err || curWrite) ? 32'd0 : loadVal;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            latWrite <= reqWrite;
            latFunc3 <= reqFunc3;
            latAddr  <= reqAddr[ADDR_W-1:0];
            latWdata <= reqWdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: storage has no reset branch; contents survive reset and a RAM macro
  // or LUT-RAM can be inferred. An aborted transaction is blocked via commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wrMask[b]) mem[curIdx][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  assign reqReady  = (state == IDLE);
  assign respValid = (state == RESP);
  assign respData  = respValid ? dataReg : 32'd0;
  assign respErr   = respValid && errReg;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Instance A: default configuration (WAIT_CYCLES=2, 256 words).
  logic        resetA = 1'b1, reqValidA = 1'b0, reqWriteA = 1'b0;
  logic [2:0]  reqFunc3A = 3'd0;
  logic [31:0] reqAddrA = 32'd0, reqWdataA = 32'd0;
  logic        reqReadyA, respValidA, respErrA;
  logic [31:0] respDataA;

  // Instance B: zero wait states.
  logic        resetB = 1'b1, reqValidB = 1'b0, reqWriteB = 1'b0;
  logic [2:0]  reqFunc3B = 3'd0;
  logic [31:0] reqAddrB = 32'd0, reqWdataB = 32'd0;
  logic        reqReadyB, respValidB, respErrB;
  logic [31:0] respDataB;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutA (
    .clk(clk), .reset(resetA), .reqValid(reqValidA), .reqWrite(reqWriteA),
    .reqFunc3(reqFunc3A), .reqAddr(reqAddrA), .reqWdata(reqWdataA),
    .reqReady(reqReadyA), .respValid(respValidA), .respData(respDataA), .respErr(respErrA)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .reset(resetB), .reqValid(reqValidB), .reqWrite(reqWriteB),
    .reqFunc3(reqFunc3B), .reqAddr(reqAddrB), .reqWdata(reqWdataB),
    .reqReady(reqReadyB), .respValid(respValidB), .respData(respDataB), .respErr(respErrB)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? reqReadyA : reqReadyB;
  endfunction

  task automatic drive(input int sel, input logic v, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      reqValidA = v; reqWriteA = w; reqFunc3A = f3; reqAddrA = a; reqWdataA = d;
    end else begin
      reqValidB = v; reqWriteB = w; reqFunc3B = f3; reqAddrB = a; reqWdataB = d;
    end
  endtask

  // Issues one request (called at a negedge), pushes the expected response
  // with the cycle it must appear in, then keeps a junk load asserted while
  // the block is busy: it must neither be accepted nor disturb the latched request.
  task automatic issue(input int sel, input string name, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] expData, input logic expErr);
    int n;
    int waitCycles;
    exp_t e;
    waitCycles = (sel == 0) ? 2 : 0;
    drive(sel, 1'b1, w, f3, a, d);
    n = 0;
    while (!readyOf(sel) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    e.name = name; e.data = expData; e.err = expErr; e.cyc = cyc + waitCycles + 1;
    if (sel == 0) qA.push_back(e); else qB.push_back(e);
    @(negedge clk);
    check({name, "_ready_busy"}, {31'd0, readyOf(sel)}, 32'd0);
    drive(sel, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'hFFFF_0000 ^ d);
    n = 0;
    while (!readyOf(sel) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Scoreboard monitors: compare every response pulse against the queue head.
  always @(negedge clk) begin
    if (!resetA) begin
      if (respValidA) begin
        if (qA.size() == 0) check("A_unexpected_resp", respDataA, 32'hXXXX_XXXX);
        else begin
          eA = qA.pop_front();
          check({"A_", eA.name, "_data"}, respDataA, eA.data);
          check({"A_", eA.name, "_err"}, {31'd0, respErrA}, {31'd0, eA.err});
          check({"A_", eA.name, "_cycle"}, cyc, eA.cyc);
        end
      end else begin
        check("A_idle_outputs_zero", {respErrA, respDataA[30:0]} | {31'd0, respDataA[31]}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!resetB && respValidB) begin
      if (qB.size() == 0) check("B_unexpected_resp", respDataB, 32'hXXXX_XXXX);
      else begin
        eB = qB.pop_front();
        check({"B_", eB.name, "_data"}, respDataB, eB.data);
        check({"B_", eB.name, "_err"}, {31'd0, respErrB}, {31'd0, eB.err});
        check({"B_", eB.name, "_cycle"}, cyc, eB.cyc);
      end
    end
  end

  initial begin
    #1;
    check("reset_ready",     {31'd0, reqReadyA},  32'd1);
    check("reset_respValid", {31'd0, respValidA}, 32'd0);
    check("reset_respData",  respDataA,           32'd0);
    check("reset_respErr",   {31'd0, respErrA},   32'd0);
    repeat (3) @(negedge clk);
    resetA = 1'b0;
    resetB = 1'b0;
    @(negedge clk);

    // Word round trip
    issue(0, "sw_10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(0, "lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD_BEEF, 1'b0);
    // Byte / half extraction
    issue(0, "sw_20",  1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'd0, 1'b0);
    issue(0, "lb_22",  1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(0, "lbu_23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
    issue(0, "lh_20",  1'b0, 3'b001, 32'h20, 32'h0, 32'h0000_7F01, 1'b0);
    issue(0, "lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_80FF, 1'b0);
    // Partial stores
    issue(0, "sw_30",  1'b1, 3'b010, 32'h30, 32'h1122_3344, 32'd0, 1'b0);
    issue(0, "sb_31",  1'b1, 3'b000, 32'h31, 32'h1234_56AA, 32'd0, 1'b0);
    issue(0, "lw_30a", 1'b0, 3'b010, 32'h30, 32'h0, 32'h1122_AA44, 1'b0);
    issue(0, "sh_32",  1'b1, 3'b001, 32'h32, 32'h5555_BEEF, 32'd0, 1'b0);
    issue(0, "lw_30b", 1'b0, 3'b010, 32'h30, 32'h0, 32'hBEEF_AA44, 1'b0);
    // Errors leave storage untouched
    issue(0, "sw_40",   1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 32'd0, 1'b0);
    issue(0, "lw_41",   1'b0, 3'b010, 32'h41, 32'h0, 32'd0, 1'b1);
    issue(0, "sh_43",   1'b1, 3'b001, 32'h43, 32'h0000_1111, 32'd0, 1'b1);
    issue(0, "f3_011",  1'b0, 3'b011, 32'h40, 32'h0, 32'd0, 1'b1);
    issue(0, "sbu_40",  1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(0, "lw_40",   1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Reset mid-WAIT aborts the store
    issue(0, "sw_50", 1'b1, 3'b010, 32'h50, 32'hCAFE_F00D, 32'd0, 1'b0);
    drive(0, 1'b1, 1'b1, 3'b010, 32'h50, 32'h1234_5678);
    @(negedge clk);                          // accepted on the edge before this
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    resetA = 1'b1;
    #1;
    check("midreset_ready",     {31'd0, reqReadyA},  32'd1);
    check("midreset_respValid", {31'd0, respValidA}, 32'd0);
    check("midreset_respData",  respDataA,           32'd0);
    check("midreset_respErr",   {31'd0, respErrA},   32'd0);
    @(negedge clk);
    @(negedge clk);
    resetA = 1'b0;
    @(negedge clk);
    issue(0, "lw_50", 1'b0, 3'b010, 32'h50, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Address aliasing modulo 1 KiB
    issue(0, "sw_400", 1'b1, 3'b010, 32'h400, 32'h600D_CAFE, 32'd0, 1'b0);
    issue(0, "lw_000", 1'b0, 3'b010, 32'h000, 32'h0, 32'h600D_CAFE, 1'b0);
    issue(0, "lw_410", 1'b0, 3'b010, 32'h410, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Zero wait states
    issue(1, "sw_08", 1'b1, 3'b010, 32'h08, 32'hA5A5_5A5A, 32'd0, 1'b0);
    issue(1, "lb_09", 1'b0, 3'b000, 32'h09, 32'h0, 32'h0000_005A, 1'b0);
    issue(1, "lh_0A", 1'b0, 3'b001, 32'h0A, 32'h0, 32'hFFFF_A5A5, 1'b0);
    issue(1, "lw_08", 1'b0, 3'b010, 32'h08, 32'h0, 32'hA5A5_5A5A, 1'b0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    repeat (10) @(negedge clk);
    check("A_queue_drained", qA.size(), 32'd0);
    check("B_queue_drained", qB.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
